mem_wb_stage: RTL

- MEM/WB pipeline register for the 5-stage RV32I core.
- Captures memory-stage results on each clock edge.
- Performs load byte/halfword alignment and sign/zero extension before the register.
- Presents three registered writeback candidates plus a 2-bit select to the writeback result 3-to-1 multiplexer:
  - data0 = ALU result
  - data1 = load data
  - data2 = PC+4

---
 rtl/mem_wb_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligns and extends load data, then registers the
// three writeback candidates, the result select and the qualified write enable.
module mem_wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      valid_m,
    input  logic [DATA_WIDTH-1:0]     alu_result_m,
    input  logic [DATA_WIDTH-1:0]     read_data_m,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic                      reg_write_m,
    input  logic [1:0]                result_src_m,
    input  logic [2:0]                funct3_m,
    output logic                      valid_w,
    output logic [DATA_WIDTH-1:0]     alu_result_w,
    output logic [DATA_WIDTH-1:0]     load_data_w,
    output logic [DATA_WIDTH-1:0]     pc_plus4_w,
    output logic [REG_ADDR_WIDTH-1:0] rd_w,
    output logic                      reg_write_w,
    output logic [1:0]                result_src_w
);

    logic [1:0]                byteOff;
    logic [7:0]                byteLane;
    logic [15:0]               halfLane;
    logic [DATA_WIDTH-1:0]     loadData;

    logic                      valid_q, valid_d;
    logic [DATA_WIDTH-1:0]     aluResult_q, aluResult_d;
    logic [DATA_WIDTH-1:0]     loadData_q, loadData_d;
    logic [DATA_WIDTH-1:0]     pcPlus4_q, pcPlus4_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      regWrite_q, regWrite_d;
    logic [1:0]                resultSrc_q, resultSrc_d;

    assign byteOff = alu_result_m[1:0];

    always_comb begin
        byteLane = read_data_m[7:0];
        case (byteOff)
            2'd0: byteLane = read_data_m[7:0];
            2'd1: byteLane = read_data_m[15:8];
            2'd2: byteLane = read_data_m[23:16];
            2'd3: byteLane = read_data_m[31:24];
            default: byteLane = read_data_m[7:0];
        endcase
        // Half-word lane ignores byteOff[0]: misaligned halves fall back to the aligned half.
        halfLane = byteOff[1] ? read_data_m[31:16] : read_data_m[15:0];
    end

    always_comb begin
        loadData = read_data_m;
        case (funct3_m)
            3'b000: loadData = {{(DATA_WIDTH-8){byteLane[7]}}, byteLane};
            3'b100: loadData = {{(DATA_WIDTH-8){1'b0}}, byteLane};
            3'b001: loadData = {{(DATA_WIDTH-16){halfLane[15]}}, halfLane};
            3'b101: loadData = {{(DATA_WIDTH-16){1'b0}}, halfLane};
            default: loadData = read_data_m;
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        aluResult_d = aluResult_q;
        loadData_d  = loadData_q;
        pcPlus4_d   = pcPlus4_q;
        rd_d        = rd_q;
        regWrite_d  = regWrite_q;
        resultSrc_d = resultSrc_q;
        if (flush) begin
            valid_d     = 1'b0;
            aluResult_d = '0;
            loadData_d  = '0;
            pcPlus4_d   = '0;
            rd_d        = '0;
            regWrite_d  = 1'b0;
            resultSrc_d = 2'b00;
        end else if (!stall) begin
            valid_d     = valid_m;
            aluResult_d = alu_result_m;
            loadData_d  = loadData;
            pcPlus4_d   = pc_plus4_m;
            rd_d        = rd_m;
            // x0 is hard-wired, so its writes are dropped before they reach the register file.
            regWrite_d  = reg_write_m & valid_m & (rd_m != '0);
            resultSrc_d = result_src_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            aluResult_q <= '0;
            loadData_q  <= '0;
            pcPlus4_q   <= '0;
            rd_q        <= '0;
            regWrite_q  <= 1'b0;
            resultSrc_q <= 2'b00;
        end else begin
            valid_q     <= valid_d;
            aluResult_q <= aluResult_d;
            loadData_q  <= loadData_d;
            pcPlus4_q   <= pcPlus4_d;
            rd_q        <= rd_d;
            regWrite_q  <= regWrite_d;
            resultSrc_q <= resultSrc_d;
        end
    end

    assign valid_w      = valid_q;
    assign alu_result_w = aluResult_q;
    assign load_data_w  = loadData_q;
    assign pc_plus4_w   = pcPlus4_q;
    assign rd_w         = rd_q;
    assign reg_write_w  = regWrite_q;
    assign result_src_w = resultSrc_q;

endmodule
